// File: rtl/rs_add_if.sv
// rs_add_if: dispatch, result-broadcast and issue bundle of the ADD station.
// master is the rename/execute side; slave is the station itself.
interface rs_add_if #(
   parameter int PW  = 5,
   parameter int OPW = 2
);
   logic           dispatch_valid;
   logic [OPW-1:0] dispatch_op;
   logic [PW-1:0]  dispatch_Pa;
   logic [PW-1:0]  dispatch_Pb;
   logic           dispatch_rdy_a;
   logic           dispatch_rdy_b;
   logic [PW-1:0]  dispatch_Pw;
   logic           full_RS;
   logic           valid_Result_add;
   logic           valid_Result_mul;
   logic [PW-1:0]  Pw_Result_add;
   logic [PW-1:0]  Pw_Result_mul;
   logic           issue_ready;
   logic           issue_valid;
   logic [OPW-1:0] issue_op;
   logic [PW-1:0]  Pa_add;
   logic [PW-1:0]  Pb_add;
   logic [PW-1:0]  Pw_issue;

   modport master (
      output dispatch_valid, dispatch_op, dispatch_Pa, dispatch_Pb,
      output dispatch_rdy_a, dispatch_rdy_b, dispatch_Pw,
      output valid_Result_add, valid_Result_mul,
      output Pw_Result_add, Pw_Result_mul, issue_ready,
      input  full_RS, issue_valid, issue_op,
      input  Pa_add, Pb_add, Pw_issue
   );

   modport slave (
      input  dispatch_valid, dispatch_op, dispatch_Pa, dispatch_Pb,
      input  dispatch_rdy_a, dispatch_rdy_b, dispatch_Pw,
      input  valid_Result_add, valid_Result_mul,
      input  Pw_Result_add, Pw_Result_mul, issue_ready,
      output full_RS, issue_valid, issue_op,
      output Pa_add, Pb_add, Pw_issue
   );
endinterface

// File: rtl/rs_add.sv
// rs_add: ADD-pipe reservation station as a compacting age-ordered queue.
// Snoops ADD/MUL broadcasts and issues the oldest fully-ready entry.
module rs_add #(
   parameter int DEPTH = 4,
   parameter int PW    = 5,
   parameter int OPW   = 2
) (
   input logic     clk,
   input logic     rst,
   input logic     flush,
   rs_add_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [PW-1:0]  pa;
      logic [PW-1:0]  pb;
      logic [PW-1:0]  pw;
      logic           ra;
      logic           rb;
   } ent_t;

   ent_t          ent_q [DEPTH];
   ent_t          ent_w [DEPTH];
   ent_t          ent_n [DEPTH];
   ent_t          sel_e;
   ent_t          dent;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_n;
   logic [CW-1:0] base;
   logic          full;
   logic          sel_found;
   logic          fire;
   logic          accept;
   int            sel;

   function automatic logic hit(
      input logic [PW-1:0] tag,
      input logic          va,
      input logic [PW-1:0] ta,
      input logic          vm,
      input logic [PW-1:0] tm
   );
      return (va && ta == tag) || (vm && tm == tag);
   endfunction

   // Oldest entry with both operands ready wins.
   always_comb begin
      sel_found = 1'b0;
      sel       = 0;
      sel_e     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!sel_found && i < int'(count_q) &&
             ent_q[i].ra && ent_q[i].rb) begin
            sel_found = 1'b1;
            sel       = i;
            sel_e     = ent_q[i];
         end
      end
   end

   assign full   = (count_q == CW'(DEPTH));
   assign fire   = sel_found & bus.issue_ready;
   assign accept = bus.dispatch_valid & ~full;

   always_comb begin
      dent.op = bus.dispatch_op;
      dent.pa = bus.dispatch_Pa;
      dent.pb = bus.dispatch_Pb;
      dent.pw = bus.dispatch_Pw;
      dent.ra = bus.dispatch_rdy_a |
                hit(bus.dispatch_Pa,
                    bus.valid_Result_add, bus.Pw_Result_add,
                    bus.valid_Result_mul, bus.Pw_Result_mul);
      dent.rb = bus.dispatch_rdy_b |
                hit(bus.dispatch_Pb,
                    bus.valid_Result_add, bus.Pw_Result_add,
                    bus.valid_Result_mul, bus.Pw_Result_mul);
      for (int i = 0; i < DEPTH; i++) begin
         ent_w[i]    = ent_q[i];
         ent_w[i].ra = ent_q[i].ra |
                       hit(ent_q[i].pa,
                           bus.valid_Result_add, bus.Pw_Result_add,
                           bus.valid_Result_mul, bus.Pw_Result_mul);
         ent_w[i].rb = ent_q[i].rb |
                       hit(ent_q[i].pb,
                           bus.valid_Result_add, bus.Pw_Result_add,
                           bus.valid_Result_mul, bus.Pw_Result_mul);
      end
      for (int i = 0; i < DEPTH; i++) begin
         ent_n[i] = ent_w[i];
      end
      // Close the gap left by the issued entry; age order is kept.
      if (fire) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (i >= sel) begin
               ent_n[i] = ent_w[i + 1];
            end
         end
         ent_n[DEPTH-1] = '0;
      end
      base = count_q - CW'(fire);
      for (int i = 0; i < DEPTH; i++) begin
         if (accept && i == int'(base)) begin
            ent_n[i] = dent;
         end
      end
      count_n = base + CW'(accept);
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         count_q <= count_n;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_n[i];
         end
      end
   end

   assign bus.full_RS     = full;
   assign bus.issue_valid = sel_found;
   assign bus.issue_op    = sel_e.op;
   assign bus.Pa_add      = sel_e.pa;
   assign bus.Pb_add      = sel_e.pb;
   assign bus.Pw_issue    = sel_e.pw;
endmodule

// File: tb/tb_rs_add.sv
// tb_rs_add: directed vector table plus flush/reset sequences for rs_add.
// Each step drives inputs at negedge, checks outputs 1ns after posedge.
module tb_rs_add;
   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   errors;

   rs_add_if #(.PW(5), .OPW(2)) bus ();

   rs_add #(.DEPTH(4), .PW(5), .OPW(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rn;
      logic       fl;
      logic       dv;
      logic [1:0] op;
      logic [4:0] pa;
      logic [4:0] pb;
      logic       ra;
      logic       rb;
      logic [4:0] pw;
      logic       va;
      logic [4:0] ta;
      logic       vm;
      logic [4:0] tm;
      logic       ir;
      int         ef;
      int         ei;
      int         eo;
      int         ea;
      int         eb;
      int         ew;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      int rn, int fl, int dv, int op, int pa, int pb, int ra, int rb,
      int pw, int va, int ta, int vm, int tm, int ir,
      int ef, int ei, int eo, int ea, int eb, int ew
   );
      vec_t v;
      v.rn = 1'(rn); v.fl = 1'(fl); v.dv = 1'(dv); v.op = 2'(op);
      v.pa = 5'(pa); v.pb = 5'(pb); v.ra = 1'(ra); v.rb = 1'(rb);
      v.pw = 5'(pw); v.va = 1'(va); v.ta = 5'(ta); v.vm = 1'(vm);
      v.tm = 5'(tm); v.ir = 1'(ir);
      v.ef = ef; v.ei = ei; v.eo = eo; v.ea = ea; v.eb = eb; v.ew = ew;
      return v;
   endfunction

   task automatic cmp(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic step(input vec_t t, input string tag);
      @(negedge clk);
      rst                  = t.rn;
      flush                = t.fl;
      bus.dispatch_valid   = t.dv;
      bus.dispatch_op      = t.op;
      bus.dispatch_Pa      = t.pa;
      bus.dispatch_Pb      = t.pb;
      bus.dispatch_rdy_a   = t.ra;
      bus.dispatch_rdy_b   = t.rb;
      bus.dispatch_Pw      = t.pw;
      bus.valid_Result_add = t.va;
      bus.Pw_Result_add    = t.ta;
      bus.valid_Result_mul = t.vm;
      bus.Pw_Result_mul    = t.tm;
      bus.issue_ready      = t.ir;
      @(posedge clk);
      #1;
      cmp({tag, " full_RS"}, int'(bus.full_RS), t.ef);
      cmp({tag, " issue_valid"}, int'(bus.issue_valid), t.ei);
      cmp({tag, " issue_op"}, int'(bus.issue_op), t.eo);
      cmp({tag, " Pa_add"}, int'(bus.Pa_add), t.ea);
      cmp({tag, " Pb_add"}, int'(bus.Pb_add), t.eb);
      cmp({tag, " Pw_issue"}, int'(bus.Pw_issue), t.ew);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      flush = 1'b0;
      bus.dispatch_valid = 1'b0;
      bus.dispatch_op = '0;
      bus.dispatch_Pa = '0;
      bus.dispatch_Pb = '0;
      bus.dispatch_rdy_a = 1'b0;
      bus.dispatch_rdy_b = 1'b0;
      bus.dispatch_Pw = '0;
      bus.valid_Result_add = 1'b0;
      bus.Pw_Result_add = '0;
      bus.valid_Result_mul = 1'b0;
      bus.Pw_Result_mul = '0;
      bus.issue_ready = 1'b0;

      // reset, fill, ignored 5th dispatch, in-order drain
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(1,0,1,1,1,2,1,1,8,0,0,0,0,0, 0,1,1,1,2,8));
      tbl.push_back(mk(1,0,1,2,12,13,1,1,9,0,0,0,0,0, 0,1,1,1,2,8));
      tbl.push_back(mk(1,0,1,3,14,15,1,1,10,0,0,0,0,0, 0,1,1,1,2,8));
      tbl.push_back(mk(1,0,1,0,16,17,1,1,11,0,0,0,0,0, 1,1,1,1,2,8));
      tbl.push_back(mk(1,0,1,1,18,19,1,1,20,0,0,0,0,0, 1,1,1,1,2,8));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,1,2,12,13,9));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,1,3,14,15,10));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,1,0,16,17,11));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
      // out-of-order ready, mul wakeup
      tbl.push_back(mk(1,0,1,2,3,4,0,1,21,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(1,0,1,1,22,23,1,1,24,0,0,0,0,0, 0,1,1,22,23,24));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,1,3,1, 0,1,2,3,4,21));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
      // dispatch bypass from add broadcast
      tbl.push_back(mk(1,0,1,3,5,25,0,1,26,1,5,0,0,0, 0,1,3,5,25,26));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
      // dual wakeup
      tbl.push_back(mk(1,0,1,1,6,7,0,0,27,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,6,1,7,0, 0,1,1,6,7,27));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
      // full with simultaneous issue and dispatch
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1,0,1,k,1,2,1,1,28+k,0,0,0,0,0,
                          (k == 3) ? 1 : 0,1,0,1,2,28));
      tbl.push_back(mk(1,0,1,1,9,10,1,1,12,0,0,0,0,1, 0,1,1,1,2,29));
      tbl.push_back(mk(1,0,1,1,9,10,1,1,12,0,0,0,0,0, 1,1,1,1,2,29));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,1,2,1,2,30));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,1,3,1,2,31));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,1,1,9,10,12));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
      // issue plus dispatch when not full: append at count-1
      tbl.push_back(mk(1,0,1,2,11,13,1,1,14,0,0,0,0,0, 0,1,2,11,13,14));
      tbl.push_back(mk(1,0,1,3,15,16,1,1,17,0,0,0,0,1, 0,1,3,15,16,17));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
      // older entry woken while younger one waits
      tbl.push_back(mk(1,0,1,1,2,9,1,0,3,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(1,0,1,2,4,5,1,1,6,0,0,0,0,0, 0,1,2,4,5,6));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,9,0,0,0, 0,1,1,2,9,3));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,1,2,4,5,6));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));

      foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

      // flush with 3 entries and a same-cycle dispatch/issue
      step(mk(1,0,1,0,1,1,1,1,1,0,0,0,0,0, 0,1,0,1,1,1), "fl_a");
      step(mk(1,0,1,1,2,2,1,1,2,0,0,0,0,0, 0,1,0,1,1,1), "fl_b");
      step(mk(1,0,1,2,3,3,1,1,3,0,0,0,0,0, 0,1,0,1,1,1), "fl_c");
      step(mk(1,1,1,3,4,4,1,1,4,0,0,0,0,1, 0,0,0,0,0,0), "fl_go");
      step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0), "fl_idle");
      // count restarted at 0: full only after the 4th dispatch
      for (int k = 0; k < 4; k++)
         step(mk(1,0,1,0,30,30,0,0,k,0,0,0,0,0,
                 (k == 3) ? 1 : 0,0,0,0,0,0),
              $sformatf("fl_fill%0d", k));
      // mid-run reset with same-cycle dispatch
      step(mk(0,0,1,1,5,5,1,1,5,0,0,0,0,1, 0,0,0,0,0,0), "rst_go");
      step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0), "rst_idle");
      step(mk(1,0,1,2,7,8,1,1,9,0,0,0,0,0, 0,1,2,7,8,9), "rst_new");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
